// File: rtl/sd_lese_arbiter.sv
// -----------------------------------------------------------------------------
// sd_lese_arbiter
//
// Shares the single SDKarte word reader between two requesters:
//   port A - CPU load path
//   port B - asset / DMA loader
// Exactly one read is outstanding at the card at any time. Simultaneous
// requests alternate round-robin. A read that the card never finishes is
// aborted by a watchdog. The block then answers every further request with
// an error reply until reset.
//
// Ports
//   Clock, Reset_n         system clock, asynchronous active-low reset
//   AnfrageA/B             level request, held until the matching Gueltig
//   AdresseA/B   [31:0]    word address, captured at grant
//   DatenA/B     [31:0]    read word, valid with Gueltig and held afterwards
//   GueltigA/B             one-cycle completion pulse
//   FehlerA/B              qualifies Gueltig: aborted or locked read (Daten=0)
//   SdAdresse    [31:0]    address to the card, stable from grant to grant
//   SdLesen                one-cycle read strobe to the card
//   SdDaten      [31:0]    card read data
//   SdFertig               card data valid (level, held during sector drain)
//   SdBusy                 card busy (level)
//   Belegt                 high whenever the arbiter is not idle
//   Zustand      [2:0]     current state code (debug)
// -----------------------------------------------------------------------------
module sd_lese_arbiter #(
    parameter int TIMEOUT_ZYKLEN = 2000000,
    parameter int ZAEHLER_BREITE = 21
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        AnfrageA,
    input  logic        AnfrageB,
    input  logic [31:0] AdresseA,
    input  logic [31:0] AdresseB,
    output logic [31:0] DatenA,
    output logic [31:0] DatenB,
    output logic        GueltigA,
    output logic        GueltigB,
    output logic        FehlerA,
    output logic        FehlerB,
    output logic [31:0] SdAdresse,
    output logic        SdLesen,
    input  logic [31:0] SdDaten,
    input  logic        SdFertig,
    input  logic        SdBusy,
    output logic        Belegt,
    output logic [2:0]  Zustand
);

    typedef enum logic [2:0] {
        WARTEN_INIT   = 3'd0,
        BEREIT        = 3'd1,
        STARTEN       = 3'd2,
        WARTEN_FERTIG = 3'd3,
        WARTEN_FREI   = 3'd4,
        GESPERRT      = 3'd5
    } zustand_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
    localparam logic [ZAEHLER_BREITE-1:0] ZAEHLER_LETZT = ZAEHLER_BREITE'(TIMEOUT_ZYKLEN - 1);

    zustand_t                  state_reg, state_next;
    logic                      letzter_reg, letzter_next;     // last port served
    logic                      port_reg, port_next;           // port owning the in-flight read
    logic [ZAEHLER_BREITE-1:0] counter_reg, counter_next;
    logic [31:0]               sd_adresse_reg, sd_adresse_next;
    logic                      sd_lesen_reg, sd_lesen_next;
    logic [31:0]               daten_a_reg, daten_a_next;
    logic [31:0]               daten_b_reg, daten_b_next;
    logic                      gueltig_a_reg, gueltig_a_next;
    logic                      gueltig_b_reg, gueltig_b_next;
    logic                      fehler_a_reg, fehler_a_next;
    logic                      fehler_b_reg, fehler_b_next;
    logic                      belegt_reg, belegt_next;

    // Arbitration. A port whose reply is being presented this cycle is not
    // considered: its Anfrage is still the old request, only a level held
    // into the following cycle counts as a new one. This only matters in
    // GESPERRT, where replies can be issued back to back.
    logic req_a, req_b, grant_any, grant_b, timeout_hit;

    always_comb begin
        req_a       = AnfrageA && !gueltig_a_reg;
        req_b       = AnfrageB && !gueltig_b_reg;
        grant_any   = req_a || req_b;
        grant_b     = req_b && (!req_a || (letzter_reg == PORT_A));
        timeout_hit = (counter_reg == ZAEHLER_LETZT);
    end

    // Process 1: state and output registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg      <= WARTEN_INIT;
            letzter_reg    <= PORT_B;          // A wins the first tie
            port_reg       <= PORT_A;
            counter_reg    <= '0;
            sd_adresse_reg <= '0;
            sd_lesen_reg   <= 1'b0;
            daten_a_reg    <= '0;
            daten_b_reg    <= '0;
            gueltig_a_reg  <= 1'b0;
            gueltig_b_reg  <= 1'b0;
            fehler_a_reg   <= 1'b0;
            fehler_b_reg   <= 1'b0;
            belegt_reg     <= 1'b1;
        end else begin
            state_reg      <= state_next;
            letzter_reg    <= letzter_next;
            port_reg       <= port_next;
            counter_reg    <= counter_next;
            sd_adresse_reg <= sd_adresse_next;
            sd_lesen_reg   <= sd_lesen_next;
            daten_a_reg    <= daten_a_next;
            daten_b_reg    <= daten_b_next;
            gueltig_a_reg  <= gueltig_a_next;
            gueltig_b_reg  <= gueltig_b_next;
            fehler_a_reg   <= fehler_a_next;
            fehler_b_reg   <= fehler_b_next;
            belegt_reg     <= belegt_next;
        end
    end

    // Process 2: next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WARTEN_INIT:   if (!SdBusy) state_next = BEREIT;
            BEREIT:        if (grant_any) state_next = STARTEN;
            STARTEN:       state_next = WARTEN_FERTIG;
            WARTEN_FERTIG: begin
                // Completion beats the watchdog when both occur together.
                if (SdFertig)         state_next = WARTEN_FREI;
                else if (timeout_hit) state_next = GESPERRT;
            end
            WARTEN_FREI:   if (!SdBusy && !SdFertig) state_next = BEREIT;
            GESPERRT:      state_next = GESPERRT;
            default:       state_next = WARTEN_INIT;
        endcase
    end

    // Process 3: next values of the registered outputs and datapath.
    always_comb begin
        letzter_next    = letzter_reg;
        port_next       = port_reg;
        counter_next    = counter_reg;
        sd_adresse_next = sd_adresse_reg;
        sd_lesen_next   = 1'b0;
        daten_a_next    = daten_a_reg;
        daten_b_next    = daten_b_reg;
        gueltig_a_next  = 1'b0;
        gueltig_b_next  = 1'b0;
        fehler_a_next   = 1'b0;
        fehler_b_next   = 1'b0;
        belegt_next     = (state_next != BEREIT);

        case (state_reg)
            BEREIT: begin
                if (grant_any) begin
                    port_next       = grant_b;
                    letzter_next    = grant_b;
                    sd_adresse_next = grant_b ? AdresseB : AdresseA;
                    sd_lesen_next   = 1'b1;    // strobe is high for the STARTEN cycle
                end
            end
            STARTEN: begin
                counter_next = '0;
            end
            WARTEN_FERTIG: begin
                if (SdFertig || timeout_hit) begin
                    if (port_reg == PORT_B) begin
                        gueltig_b_next = 1'b1;
                        fehler_b_next  = !SdFertig;
                        daten_b_next   = SdFertig ? SdDaten : 32'd0;
                    end else begin
                        gueltig_a_next = 1'b1;
                        fehler_a_next  = !SdFertig;
                        daten_a_next   = SdFertig ? SdDaten : 32'd0;
                    end
                end else begin
                    counter_next = counter_reg + ZAEHLER_BREITE'(1);
                end
            end
            GESPERRT: begin
                // Locked: every request gets an immediate error reply.
                if (grant_any) begin
                    letzter_next = grant_b;
                    if (grant_b) begin
                        gueltig_b_next = 1'b1;
                        fehler_b_next  = 1'b1;
                        daten_b_next   = 32'd0;
                    end else begin
                        gueltig_a_next = 1'b1;
                        fehler_a_next  = 1'b1;
                        daten_a_next   = 32'd0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign DatenA    = daten_a_reg;
    assign DatenB    = daten_b_reg;
    assign GueltigA  = gueltig_a_reg;
    assign GueltigB  = gueltig_b_reg;
    assign FehlerA   = fehler_a_reg;
    assign FehlerB   = fehler_b_reg;
    assign SdAdresse = sd_adresse_reg;
    assign SdLesen   = sd_lesen_reg;
    assign Belegt    = belegt_reg;
    assign Zustand   = state_reg;

endmodule

// File: doc/sd_lese_arbiter.md
# sd_lese_arbiter

Arbitrates 32-bit word reads from two requesters onto the single SDKarte word reader. Port A is the CPU load path and port B is the asset/DMA loader. Only one read is ever outstanding at SDKarte. Requesters that issue simultaneously are served round-robin. A read that never completes is terminated by a watchdog, and the block then locks into an error-reply mode until reset.

## Interface
- TIMEOUT_ZYKLEN, default 2000000: cycles allowed between the SdLesen pulse and SdFertig before the read is aborted.
- ZAEHLER_BREITE, default 21: width of the watchdog counter; must hold TIMEOUT_ZYKLEN-1.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- AnfrageA / AnfrageB  in  1  level read request; hold until the matching Gueltig pulse.
- AdresseA / AdresseB  in  32  word address; latched at grant.
- DatenA / DatenB  out  32  read word; valid while Gueltig is high, then held.
- GueltigA / GueltigB  out  1  one-cycle completion pulse.
- FehlerA / FehlerB  out  1  qualifies Gueltig: 1 means aborted or locked read, with Daten=0.
- SdAdresse  out  32  address to SDKarte; stable from grant until the next grant.
- SdLesen  out  1  one-cycle read strobe to SDKarte.
- SdDaten  in  32  SDKarte read data.
- SdFertig  in  1  SDKarte data valid (level; stays high until the sector drains).
- SdBusy  in  1  SDKarte busy (level).
- Belegt  out  1  high whenever the state is not BEREIT.
- Zustand  out  3  state code, for debug.

## Operation
- States and codes: WARTEN_INIT=0, BEREIT=1, STARTEN=2, WARTEN_FERTIG=3, WARTEN_FREI=4, GESPERRT=5.
- WARTEN_INIT: wait for SdBusy=0, then go to BEREIT. No timeout applies here, because card init is long.
- BEREIT, grant rules:
  - Only one requester high: grant it.
  - Both high: grant the port not equal to `letzter`.
  - Neither high: stay.
- On a grant:
  - latch the address into SdAdresse;
  - record the granted port and set `letzter` to it;
  - go to STARTEN.
- STARTEN: SdLesen=1 for exactly this cycle. Clear the watchdog counter and go to WARTEN_FERTIG.
- WARTEN_FERTIG, each cycle in this order:
  - SdFertig=1: capture SdDaten into the granted port's Daten, pulse its Gueltig with Fehler=0, go to WARTEN_FREI.
  - Otherwise, counter == TIMEOUT_ZYKLEN-1: Daten=0, pulse Gueltig with Fehler=1, go to GESPERRT.
  - Otherwise: increment the counter.
- SdFertig and timeout in the same cycle: SdFertig wins.
- WARTEN_FREI: wait until SdBusy=0 and SdFertig=0, then go to BEREIT. A SdFertig level held during the sector drain must not produce a second Gueltig.
- GESPERRT (sticky until reset):
  - SdLesen is never asserted again.
  - Each request is answered by round-robin, one per cycle: Gueltig+Fehler=1, Daten=0, one cycle after it is sampled.
- Requests are committed at grant. Dropping Anfrage afterwards does not cancel the reply.
- If a requester still holds Anfrage in the cycle after Gueltig, it is re-granted as a new read (subject to round-robin).
- Gueltig and Fehler of the port not being served stay 0.

## Timing
- Reset values (asynchronous on Reset_n=0):
  - state=WARTEN_INIT; Belegt=1; Zustand=0;
  - SdLesen=0; SdAdresse=0;
  - DatenA=DatenB=0; GueltigA/B=0; FehlerA/B=0;
  - `letzter`=B, so A wins the first tie;
  - counter=0.
- Reset mid-transaction discards the in-flight reply: no Gueltig follows release. SDKarte is reset by the same top-level reset.
- All outputs are registered.
- Grant sampled at edge E0 → SdLesen high E0..E1.
- SdFertig first sampled high at edge Ek → Gueltig high Ek..Ek+1, with Daten updated at Ek.
- Minimum request-to-Gueltig latency is 3 cycles (zero-delay SdFertig); the next grant comes 1 cycle after SdBusy=SdFertig=0 is sampled.
- Watchdog: with SdLesen at E0, an abort Gueltig appears at edge E0+1+TIMEOUT_ZYKLEN.
- BEREIT is entered only with SdBusy=0, so SdLesen is never issued while SdBusy=1.

## Test plan
- Reset release with SdBusy=1 for 100 cycles: SdLesen stays 0, Belegt=1, Zustand=0. On SdBusy→0: Zustand=1 the next cycle, Belegt=0.
- AnfrageA, AdresseA=0x00000085; the model raises SdFertig with SdDaten=0xDEADBEEF 20 cycles after SdLesen:
  - exactly one SdLesen pulse, with SdAdresse=0x85;
  - GueltigA for one cycle with DatenA=0xDEADBEEF, FehlerA=0;
  - no GueltigB;
  - SdFertig held for 50 more cycles gives no second pulse.
- AnfrageA and AnfrageB held continuously from reset, addresses 0x10/0x20: grants go A,B,A,B over four reads, SdAdresse alternates 0x10/0x20, and each reply goes to the correct port.
- TIMEOUT_ZYKLEN=64, model never raises SdFertig:
  - GueltigA with FehlerA=1 and DatenA=0 exactly 65 cycles after the SdLesen edge, then Zustand=5;
  - a later AnfrageB gets GueltigB+FehlerB one cycle after sampling, with no SdLesen.
- Reset_n pulsed low during WARTEN_FERTIG: all outputs clear immediately, with no Gueltig after release until a new request completes.
- AnfrageB dropped the cycle after grant: GueltigB is still delivered with the correct data.
